// File: rtl/lcd_write_sequencer_if.sv
// Write-request channel between the LCD init/text FSM and the LCD write sequencer.
interface lcd_write_sequencer_if;
  logic       wr_valid;
  logic       wr_ready;
  logic       wr_rs;
  logic [7:0] wr_data;
  logic       busy;

  modport master (output wr_valid, output wr_rs, output wr_data, input wr_ready, input busy);
  modport slave  (input wr_valid, input wr_rs, input wr_data, output wr_ready, output busy);
endinterface

// File: rtl/lcd_write_sequencer.sv
// Turns accepted byte writes into HD44780 8-bit bus cycles (setup, E pulse, execution hold),
// timing each phase off the delay flags of an external flag_controller restarted via flag_rst.
module lcd_write_sequencer #(
  parameter bit SKIP_PWRUP  = 1'b0,
  parameter bit LONG_CMD_EN = 1'b1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  lcd_write_sequencer_if.slave        wr,
  output logic                        flag_rst,
  input  logic                        flag_250ns,
  input  logic                        flag_42us,
  input  logic                        flag_1640us,
  input  logic                        flag_15000us,
  output logic                        lcd_e,
  output logic                        lcd_rs,
  output logic                        lcd_rw,
  output logic [7:0]                  lcd_data
);

  typedef enum logic [2:0] {
    S_PWRUP,
    S_IDLE,
    S_SETUP,
    S_ENABLE,
    S_HOLD
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic       e_nxt;
  logic       rs_nxt;
  logic [7:0] data_nxt;
  logic       flag_rst_nxt;
  logic       ready_q;
  logic       busy_q;
  logic       flags_ok;
  logic       long_cmd;
  logic       accept;
  logic       hold_done;

  // The controller's counters only restart on the edge after flag_rst rises,
  // so its flags are stale in any cycle where flag_rst is still high.
  assign flags_ok  = !flag_rst;
  assign accept    = wr.wr_valid && ready_q;
  assign long_cmd  = LONG_CMD_EN && !lcd_rs &&
                     ((lcd_data == 8'h01) || (lcd_data == 8'h02) || (lcd_data == 8'h03));
  assign hold_done = long_cmd ? flag_1640us : flag_42us;

  assign lcd_rw      = 1'b0;
  assign wr.wr_ready = ready_q;
  assign wr.busy     = busy_q;

  always_comb begin
    state_nxt    = state;
    e_nxt        = 1'b0;
    rs_nxt       = lcd_rs;
    data_nxt     = lcd_data;
    flag_rst_nxt = 1'b0;
    case (state)
      S_PWRUP: begin
        if (flags_ok && flag_15000us) begin
          state_nxt    = S_IDLE;
          flag_rst_nxt = 1'b1;
        end
      end
      S_IDLE: begin
        flag_rst_nxt = 1'b1;
        if (accept) begin
          state_nxt = S_SETUP;
          rs_nxt    = wr.wr_rs;
          data_nxt  = wr.wr_data;
        end
      end
      S_SETUP: begin
        state_nxt = S_ENABLE;
        e_nxt     = 1'b1;
      end
      S_ENABLE: begin
        if (flags_ok && flag_250ns) begin
          state_nxt    = S_HOLD;
          flag_rst_nxt = 1'b1;
        end else begin
          e_nxt = 1'b1;
        end
      end
      S_HOLD: begin
        if (flags_ok && hold_done) begin
          state_nxt    = S_IDLE;
          flag_rst_nxt = 1'b1;
        end
      end
      default: begin
        state_nxt    = S_PWRUP;
        flag_rst_nxt = 1'b1;
      end
    endcase
  end

  // Every output is loaded from its next-state value so the pins are glitch-free.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= SKIP_PWRUP ? S_IDLE : S_PWRUP;
      lcd_e    <= 1'b0;
      lcd_rs   <= 1'b0;
      lcd_data <= 8'h00;
      ready_q  <= 1'b0;
      busy_q   <= 1'b1;
      flag_rst <= 1'b1;
    end else begin
      state    <= state_nxt;
      lcd_e    <= e_nxt;
      lcd_rs   <= rs_nxt;
      lcd_data <= data_nxt;
      ready_q  <= (state_nxt == S_IDLE);
      busy_q   <= (state_nxt != S_IDLE);
      flag_rst <= flag_rst_nxt;
    end
  end

endmodule

// File: tb/tb_lcd_write_sequencer.sv
// Directed bench for lcd_write_sequencer with a shortened behavioural flag_controller per instance.
module tb_lcd_write_sequencer;

  localparam int T250   = 13;
  localparam int T42    = 40;
  localparam int T1640  = 150;
  localparam int T15000 = 300;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  lcd_write_sequencer_if wif0();
  lcd_write_sequencer_if wif1();

  logic       flag_rst0, flag_rst1;
  logic       lcd_e0, lcd_rs0, lcd_rw0, lcd_e1, lcd_rs1, lcd_rw1;
  logic [7:0] lcd_data0, lcd_data1;
  int         cnt0, cnt1;
  logic       f250_0, f42_0, f1640_0, f15000_0;
  logic       f250_1, f42_1, f1640_1, f15000_1;

  // Flag model: counter clears while flag_rst is sampled high, flags are thresholds on it.
  always @(posedge clk) begin
    if (!rst_n || flag_rst0) cnt0 <= 0;
    else if (cnt0 < 1000000) cnt0 <= cnt0 + 1;
    if (!rst_n || flag_rst1) cnt1 <= 0;
    else if (cnt1 < 1000000) cnt1 <= cnt1 + 1;
  end
  assign f250_0   = (cnt0 >= T250);
  assign f42_0    = (cnt0 >= T42);
  assign f1640_0  = (cnt0 >= T1640);
  assign f15000_0 = (cnt0 >= T15000);
  assign f250_1   = (cnt1 >= T250);
  assign f42_1    = (cnt1 >= T42);
  assign f1640_1  = (cnt1 >= T1640);
  assign f15000_1 = (cnt1 >= T15000);

  lcd_write_sequencer #(.SKIP_PWRUP(1'b0), .LONG_CMD_EN(1'b1)) dut0 (
    .clk(clk), .rst_n(rst_n), .wr(wif0), .flag_rst(flag_rst0),
    .flag_250ns(f250_0), .flag_42us(f42_0), .flag_1640us(f1640_0), .flag_15000us(f15000_0),
    .lcd_e(lcd_e0), .lcd_rs(lcd_rs0), .lcd_rw(lcd_rw0), .lcd_data(lcd_data0)
  );

  lcd_write_sequencer #(.SKIP_PWRUP(1'b1), .LONG_CMD_EN(1'b0)) dut1 (
    .clk(clk), .rst_n(rst_n), .wr(wif1), .flag_rst(flag_rst1),
    .flag_250ns(f250_1), .flag_42us(f42_1), .flag_1640us(f1640_1), .flag_15000us(f15000_1),
    .lcd_e(lcd_e1), .lcd_rs(lcd_rs1), .lcd_rw(lcd_rw1), .lcd_data(lcd_data1)
  );

  int         sel = 0;
  logic       v_e, v_rs, v_rw, v_ready, v_busy;
  logic [7:0] v_data;
  always_comb begin
    v_e = lcd_e0; v_rs = lcd_rs0; v_rw = lcd_rw0; v_data = lcd_data0;
    v_ready = wif0.wr_ready; v_busy = wif0.busy;
    if (sel == 1) begin
      v_e = lcd_e1; v_rs = lcd_rs1; v_rw = lcd_rw1; v_data = lcd_data1;
      v_ready = wif1.wr_ready; v_busy = wif1.busy;
    end
  end

  // E-pulse monitor on instance 0
  bit         mon_on = 1'b0;
  logic       prev_e0 = 1'b0;
  int         rw_bad_cnt = 0;
  logic [7:0] pulses[$];
  always @(negedge clk) begin
    if (mon_on) begin
      if (lcd_e0 && !prev_e0) pulses.push_back(lcd_data0);
      if (lcd_rw0 !== 1'b0) rw_bad_cnt <= rw_bad_cnt + 1;
    end
    prev_e0 <= lcd_e0;
  end

  task automatic drive(input logic valid, input logic rs, input logic [7:0] d);
    if (sel == 1) begin
      wif1.wr_valid = valid; wif1.wr_rs = rs; wif1.wr_data = d;
    end else begin
      wif0.wr_valid = valid; wif0.wr_rs = rs; wif0.wr_data = d;
    end
  endtask

  // Performs one write on instance s and measures E width and hold length (in cycles).
  task automatic run_write(input int s, input logic rs, input logic [7:0] d,
                           output int e_hi, output int hold, output bit setup_ok,
                           output bit bus_ok, output bit to);
    int k;
    sel = s; to = 0; setup_ok = 0; bus_ok = 1; e_hi = 0; hold = 0;
    k = 0;
    while (v_ready !== 1'b1 && k < 1000) begin @(negedge clk); k++; end
    if (v_ready !== 1'b1) begin to = 1; return; end
    drive(1'b1, rs, d);
    @(posedge clk); #1;
    drive(1'b0, ~rs, ~d);
    @(negedge clk);
    setup_ok = (v_e === 1'b0 && v_rs === rs && v_data === d && v_ready === 1'b0 && v_busy === 1'b1);
    for (k = 0; k < 100; k++) begin
      @(negedge clk);
      if (v_data !== d || v_rs !== rs || v_rw !== 1'b0) bus_ok = 0;
      drive(1'b0, 1'($urandom), 8'($urandom));
      if (v_e !== 1'b1) break;
      e_hi++;
    end
    if (k == 100) begin to = 1; return; end
    hold = 1;
    for (k = 0; k < 1000; k++) begin
      @(negedge clk);
      if (v_ready === 1'b1) break;
      if (v_data !== d || v_rs !== rs || v_rw !== 1'b0 || v_e !== 1'b0) bus_ok = 0;
      drive(1'b0, 1'($urandom), 8'($urandom));
      hold++;
    end
    if (k == 1000) to = 1;
    if (v_data !== d || v_rs !== rs || v_e !== 1'b0 || v_busy !== 1'b0) bus_ok = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    sel = 0; drive(1'b0, 1'b0, 8'h00);
    sel = 1; drive(1'b0, 1'b0, 8'h00);
    sel = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (lcd_e0 !== 1'b0) begin errors++; $display("FAIL reset_lcd_e got=%b exp=0", lcd_e0); end
    checks++; if (lcd_rs0 !== 1'b0) begin errors++; $display("FAIL reset_lcd_rs got=%b exp=0", lcd_rs0); end
    checks++; if (lcd_rw0 !== 1'b0) begin errors++; $display("FAIL reset_lcd_rw got=%b exp=0", lcd_rw0); end
    checks++; if (lcd_data0 !== 8'h00) begin errors++; $display("FAIL reset_lcd_data got=%h exp=00", lcd_data0); end
    checks++; if (wif0.wr_ready !== 1'b0) begin errors++; $display("FAIL reset_wr_ready got=%b exp=0", wif0.wr_ready); end
    checks++; if (wif0.busy !== 1'b1) begin errors++; $display("FAIL reset_busy got=%b exp=1", wif0.busy); end
    checks++; if (flag_rst0 !== 1'b1) begin errors++; $display("FAIL reset_flag_rst got=%b exp=1", flag_rst0); end
    checks++; if (wif1.wr_ready !== 1'b0) begin errors++; $display("FAIL reset_skip_wr_ready got=%b exp=0", wif1.wr_ready); end
  endtask

  task automatic test_powerup();
    int  n;
    bit  seen;
    bit  early;
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (wif1.wr_ready !== 1'b1 || wif1.busy !== 1'b0) begin
      errors++; $display("FAIL skip_pwrup_idle got ready=%b busy=%b exp ready=1 busy=0", wif1.wr_ready, wif1.busy);
    end
    checks++; if (flag_rst0 !== 1'b0) begin errors++; $display("FAIL pwrup_flag_rst_drop got=%b exp=0", flag_rst0); end
    seen = 0; early = 0; n = 0;
    for (int k = 1; k <= T15000 + 20; k++) begin
      @(negedge clk);
      if (wif0.wr_ready === 1'b1) begin n = k; seen = 1; break; end
      if (wif0.busy !== 1'b1 || lcd_e0 !== 1'b0) early = 1;
    end
    checks++; if (!seen || n != T15000 + 1) begin
      errors++; $display("FAIL pwrup_delay got=%0d seen=%0d exp=%0d", n, seen, T15000 + 1);
    end
    checks++; if (early || wif0.busy !== 1'b0) begin errors++; $display("FAIL pwrup_busy got early=%0d busy=%b exp early=0 busy=0", early, wif0.busy); end
  endtask

  task automatic test_data_write();
    int e_hi, hold; bit su, bus, to;
    run_write(0, 1'b1, 8'h41, e_hi, hold, su, bus, to);
    checks++; if (to) begin errors++; $display("FAIL data_write_timeout got=1 exp=0"); end
    checks++; if (!su) begin errors++; $display("FAIL data_write_setup got=0 exp=1 (rs/data valid, e low)"); end
    checks++; if (e_hi != T250 + 1) begin errors++; $display("FAIL data_write_e_width got=%0d exp=%0d", e_hi, T250 + 1); end
    checks++; if (hold != T42 + 2) begin errors++; $display("FAIL data_write_hold got=%0d exp=%0d", hold, T42 + 2); end
    checks++; if (!bus) begin errors++; $display("FAIL data_write_bus got=0 exp=1"); end
  endtask

  task automatic test_clear_command();
    int e_hi, hold; bit su, bus, to;
    run_write(0, 1'b0, 8'h01, e_hi, hold, su, bus, to);
    checks++; if (to || hold != T1640 + 2) begin errors++; $display("FAIL clear_hold got=%0d to=%0d exp=%0d", hold, to, T1640 + 2); end
    checks++; if (e_hi != T250 + 1) begin errors++; $display("FAIL clear_e_width got=%0d exp=%0d", e_hi, T250 + 1); end
    run_write(0, 1'b0, 8'h03, e_hi, hold, su, bus, to);
    checks++; if (to || hold != T1640 + 2) begin errors++; $display("FAIL cmd03_hold got=%0d to=%0d exp=%0d", hold, to, T1640 + 2); end
    run_write(0, 1'b0, 8'h04, e_hi, hold, su, bus, to);
    checks++; if (to || hold != T42 + 2) begin errors++; $display("FAIL cmd04_hold got=%0d to=%0d exp=%0d", hold, to, T42 + 2); end
    run_write(0, 1'b1, 8'h01, e_hi, hold, su, bus, to);
    checks++; if (to || hold != T42 + 2) begin errors++; $display("FAIL data01_hold got=%0d to=%0d exp=%0d", hold, to, T42 + 2); end
    run_write(1, 1'b0, 8'h01, e_hi, hold, su, bus, to);
    checks++; if (to || hold != T42 + 2) begin errors++; $display("FAIL clear_nolong_hold got=%0d to=%0d exp=%0d", hold, to, T42 + 2); end
    checks++; if (!su || !bus) begin errors++; $display("FAIL clear_nolong_bus got su=%0d bus=%0d exp 1/1", su, bus); end
    sel = 0;
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_b [3];
    int         base, rwb, k;
    exp_b = '{8'h38, 8'h0C, 8'h06};
    sel = 0;
    base = pulses.size();
    rwb = rw_bad_cnt;
    mon_on = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, exp_b[i]);
      k = 0;
      while (v_ready !== 1'b1 && k < 1000) begin @(negedge clk); k++; end
      @(posedge clk); #1;
      checks++; if (v_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_drop_%0d got=%b exp=0", i, v_ready); end
    end
    drive(1'b0, 1'b0, 8'h00);
    k = 0;
    while (v_ready !== 1'b1 && k < 1000) begin @(negedge clk); k++; end
    repeat (3) @(negedge clk);
    mon_on = 1'b0;
    checks++; if (pulses.size() - base != 3) begin errors++; $display("FAIL b2b_pulse_count got=%0d exp=3", pulses.size() - base); end
    else begin
      for (int i = 0; i < 3; i++) begin
        checks++; if (pulses[base + i] !== exp_b[i]) begin errors++; $display("FAIL b2b_data_%0d got=%h exp=%h", i, pulses[base + i], exp_b[i]); end
      end
    end
    checks++; if (rw_bad_cnt != rwb) begin errors++; $display("FAIL b2b_rw got=%0d bad cycles exp=0", rw_bad_cnt - rwb); end
  endtask

  task automatic test_bus_stability();
    int e_hi, hold; bit su, bus, to;
    run_write(0, 1'b1, 8'hA5, e_hi, hold, su, bus, to);
    checks++; if (to || !su || !bus) begin errors++; $display("FAIL bus_stability got to=%0d su=%0d bus=%0d exp 0/1/1", to, su, bus); end
  endtask

  task automatic test_reset_mid_enable();
    int k, n; bit seen;
    sel = 0;
    drive(1'b1, 1'b1, 8'h80);
    k = 0;
    while (v_ready !== 1'b1 && k < 1000) begin @(negedge clk); k++; end
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 8'h00);
    k = 0;
    while (lcd_e0 !== 1'b1 && k < 100) begin @(negedge clk); k++; end
    checks++; if (lcd_e0 !== 1'b1) begin errors++; $display("FAIL mid_enable_reach got=%b exp=1", lcd_e0); end
    rst_n = 1'b0;
    @(posedge clk); #1;
    checks++; if (lcd_e0 !== 1'b0) begin errors++; $display("FAIL mid_rst_lcd_e got=%b exp=0", lcd_e0); end
    checks++; if (flag_rst0 !== 1'b1) begin errors++; $display("FAIL mid_rst_flag_rst got=%b exp=1", flag_rst0); end
    checks++; if (wif0.wr_ready !== 1'b0 || wif0.busy !== 1'b1) begin
      errors++; $display("FAIL mid_rst_handshake got ready=%b busy=%b exp 0/1", wif0.wr_ready, wif0.busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0; n = 0;
    for (int j = 0; j <= T15000 + 20; j++) begin
      @(negedge clk);
      if (wif0.wr_ready === 1'b1) begin n = j; seen = 1; break; end
    end
    checks++; if (!seen || n != T15000 + 1) begin errors++; $display("FAIL mid_rst_pwrup got=%0d seen=%0d exp=%0d", n, seen, T15000 + 1); end
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_powerup();
    test_data_write();
    test_clear_command();
    test_back_to_back();
    test_bus_stability();
    test_reset_mid_enable();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
